// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM states and
// address/strobe helpers for the register responder.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_e;

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    function automatic logic idx_in_range(input logic [31:0] idx,
                                          input int unsigned n);
        return idx < n;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = wdata[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave exposing a bank of 32-bit registers to fabric logic.
// Register 0 is a read-only identifier; writes to it answer SLVERR.
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'h5052_4F50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    s_awaddr,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [ADDR_WIDTH-1:0]    s_araddr,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [32*NUM_REGS-1:0] REGS_RST =
        {{((NUM_REGS-1)*32){1'b0}}, ID_VALUE};

    wstate_e                     wstate_q, wstate_d;
    logic                        awready_q, awready_d;
    logic                        wready_q, wready_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]       awaddr_q, awaddr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [3:0]                  wstrb_q, wstrb_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-1:0][31:0]   regs_q, regs_d;

    rstate_e                     rstate_q, rstate_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [31:0]                 rdata_q, rdata_d;

    logic                        aw_hs, w_hs;
    logic [31:0]                 widx, ridx, wd;
    logic [3:0]                  ws;

    always_comb begin
        wstate_d   = wstate_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        aw_hs      = s_awvalid && awready_q;
        w_hs       = s_wvalid && wready_q;
        widx       = word_index(32'(aw_hs ? s_awaddr : awaddr_q));
        wd         = w_hs ? s_wdata : wdata_q;
        ws         = w_hs ? s_wstrb : wstrb_q;
        unique case (wstate_q)
            W_COLLECT: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_awaddr;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                awready_d = !aw_done_d;
                wready_d  = !w_done_d;
                // Commit on the edge that completes the AW/W pair.
                if (aw_done_d && w_done_d) begin
                    wstate_d  = W_RESP;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    if (!idx_in_range(widx, NUM_REGS)) begin
                        bresp_d = AXI_RESP_DECERR;
                    end else if (widx == 0) begin
                        bresp_d = AXI_RESP_SLVERR;
                    end else begin
                        bresp_d = AXI_RESP_OKAY;
                        regs_d[widx[IW-1:0]] =
                            strb_merge(regs_q[widx[IW-1:0]], wd, ws);
                        wr_pulse_d[widx[IW-1:0]] = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    wstate_d  = W_COLLECT;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        ridx      = word_index(32'(s_araddr));
        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_arvalid && arready_q) begin
                    rstate_d  = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    if (!idx_in_range(ridx, NUM_REGS)) begin
                        rdata_d = '0;
                        rresp_d = AXI_RESP_DECERR;
                    end else begin
                        rdata_d = (ridx == 0) ? ID_VALUE
                                              : regs_q[ridx[IW-1:0]];
                        rresp_d = AXI_RESP_OKAY;
                    end
                end
            end
            R_RESP: begin
                if (s_rready) begin
                    rstate_d  = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate_q   <= W_COLLECT;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            wr_pulse_q <= '0;
            regs_q     <= REGS_RST;
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wstate_q   <= wstate_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rstate_q   <= rstate_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_awready  = awready_q;
    assign s_wready   = wready_q;
    assign s_bvalid   = bvalid_q;
    assign s_bresp    = bresp_q;
    assign s_arready  = arready_q;
    assign s_rvalid   = rvalid_q;
    assign s_rresp    = rresp_q;
    assign s_rdata    = rdata_q;
    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
// Bench for axil_reg_responder: directed cases plus random traffic
// checked against an array-based register model.
module tb_axil_reg_responder;

    localparam int          AW  = 12;
    localparam int          NR  = 16;
    localparam logic [31:0] IDV = 32'h5052_4F50;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AW-1:0]     s_awaddr = '0;
    logic              s_awvalid = 1'b0;
    logic              s_awready;
    logic [31:0]       s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready = 1'b0;
    logic [AW-1:0]     s_araddr = '0;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready = 1'b0;
    logic [32*NR-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;

    int checks = 0;
    int fails  = 0;
    logic [31:0] mregs [NR];

    always #5 clk = ~clk;

    axil_reg_responder #(
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR),
        .ID_VALUE  (IDV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .regs_o    (regs_o),
        .wr_pulse_o(wr_pulse_o)
    );

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*NR-1:0] mflat();
        logic [32*NR-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = mregs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mregs[i] = 32'h0;
        mregs[0] = IDV;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp,
                               output logic [NR-1:0] pulse);
        int idx;
        idx   = int'(a) / 4;
        pulse = '0;
        if (idx >= NR) begin
            resp = 2'b11;
        end else if (idx == 0) begin
            resp = 2'b10;
        end else begin
            for (int k = 0; k < 4; k++)
                if (s[k]) mregs[idx][8*k +: 8] = d[8*k +: 8];
            pulse[idx] = 1'b1;
            resp = 2'b00;
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d,
                              output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NR) begin
            d = 32'h0;
            resp = 2'b11;
        end else begin
            d = mregs[idx];
            resp = 2'b00;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int awd, input int wd,
                             input int bdly);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0] er;
        logic [NR-1:0] ep;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        s_awaddr = a;
        s_wdata  = d;
        s_wstrb  = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_awvalid = !aw_done && cyc >= awd;
            s_wvalid  = !w_done && cyc >= wd;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick();
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("wr_handshake_done", 512'(aw_done && w_done), 512'(1));
        model_write(a, d, s, er, ep);
        chk("bvalid_rise", 512'(s_bvalid), 512'(1));
        chk("bresp", 512'(s_bresp), 512'(er));
        chk("wr_pulse", 512'(wr_pulse_o), 512'(ep));
        chk("regs_after_write", 512'(regs_o), 512'(mflat()));
        for (int i = 0; i < bdly; i++) begin
            tick();
            chk("bvalid_hold", 512'(s_bvalid), 512'(1));
            chk("bresp_hold", 512'(s_bresp), 512'(er));
            chk("wr_pulse_once", 512'(wr_pulse_o), 512'(0));
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("bvalid_drop", 512'(s_bvalid), 512'(0));
        chk("wr_pulse_clear", 512'(wr_pulse_o), 512'(0));
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int rdly);
        bit done, hs;
        int cyc;
        logic [31:0] ed;
        logic [1:0] er;
        done = 0;
        cyc  = 0;
        s_araddr = a;
        while (!done && cyc < 50) begin
            s_arvalid = 1'b1;
            hs = s_arready;
            tick();
            done = hs;
            cyc++;
        end
        s_arvalid = 1'b0;
        chk("rd_handshake_done", 512'(done), 512'(1));
        model_read(a, ed, er);
        chk("rvalid_rise", 512'(s_rvalid), 512'(1));
        chk("rdata", 512'(s_rdata), 512'(ed));
        chk("rresp", 512'(s_rresp), 512'(er));
        for (int i = 0; i < rdly; i++) begin
            tick();
            chk("rvalid_hold", 512'(s_rvalid), 512'(1));
            chk("rdata_hold", 512'(s_rdata), 512'(ed));
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("rvalid_drop", 512'(s_rvalid), 512'(0));
    endtask

    initial begin
        logic [AW-1:0] a;
        model_reset();

        // Reset state and ready rise
        tick();
        tick();
        chk("rst_bvalid", 512'(s_bvalid), 512'(0));
        chk("rst_rvalid", 512'(s_rvalid), 512'(0));
        chk("rst_readys", 512'({s_awready, s_wready, s_arready}), 512'(0));
        chk("rst_rdata", 512'({s_rdata, s_rresp, s_bresp}), 512'(0));
        chk("rst_regs", 512'(regs_o), 512'(mflat()));
        chk("rst_pulse", 512'(wr_pulse_o), 512'(0));
        rst = 1'b1;
        tick();
        chk("ready_after_rst", 512'({s_awready, s_wready, s_arready}),
            512'(3'b111));

        axi_read(12'h000, 0);
        chk("id_value", 512'(s_rdata), 512'(IDV));
        axi_read(12'h004, 1);

        axi_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg2_full", 512'(regs_o[64 +: 32]), 512'(32'hDEADBEEF));
        axi_read(12'h008, 0);

        axi_write(12'h008, 32'h000000AA, 4'h1, 3, 0, 4);
        chk("reg2_byte0", 512'(regs_o[64 +: 32]), 512'(32'hDEADBEAA));

        axi_write(12'h000, 32'h12345678, 4'hF, 1, 0, 0);
        chk("id_unchanged", 512'(regs_o[31:0]), 512'(IDV));
        axi_write(12'h040, 32'hFFFFFFFF, 4'hF, 0, 2, 1);
        axi_read(12'h040, 2);
        axi_write(12'h014, 32'hCAFEF00D, 4'h0, 0, 0, 0);

        // Read sampling and write committing reg 3 on the same edge
        axi_write(12'h00C, 32'h1, 4'hF, 0, 0, 0);
        chk("same_edge_readys", 512'({s_awready, s_wready, s_arready}),
            512'(3'b111));
        s_awaddr  = 12'h00C;
        s_wdata   = 32'h2;
        s_wstrb   = 4'hF;
        s_araddr  = 12'h00C;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        mregs[3] = 32'h2;
        chk("same_edge_rvalid", 512'(s_rvalid), 512'(1));
        chk("same_edge_bvalid", 512'(s_bvalid), 512'(1));
        chk("same_edge_old", 512'(s_rdata), 512'(32'h1));
        chk("same_edge_reg", 512'(regs_o), 512'(mflat()));
        s_bready = 1'b1;
        s_rready = 1'b1;
        tick();
        s_bready = 1'b0;
        s_rready = 1'b0;
        chk("same_edge_done", 512'({s_bvalid, s_rvalid}), 512'(0));
        axi_read(12'h00C, 0);

        // Reset while a write response is pending
        s_awaddr  = 12'h014;
        s_wdata   = 32'h1234;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("pre_rst_bvalid", 512'(s_bvalid), 512'(1));
        rst = 1'b0;
        tick();
        model_reset();
        chk("midrst_bvalid", 512'(s_bvalid), 512'(0));
        chk("midrst_regs", 512'(regs_o), 512'(mflat()));
        chk("midrst_readys", 512'({s_awready, s_wready, s_arready}),
            512'(0));
        rst = 1'b1;
        tick();
        chk("midrst_ready_rise", 512'({s_awready, s_wready, s_arready}),
            512'(3'b111));
        chk("midrst_no_resp", 512'(s_bvalid), 512'(0));
        axi_write(12'h014, 32'hA5A5A5A5, 4'hF, 0, 1, 0);
        axi_read(12'h014, 0);

        // Random traffic, including out-of-range and unaligned addresses
        for (int n = 0; n < 60; n++) begin
            a = AW'($urandom_range(0, NR + 3) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end
        chk("final_regs", 512'(regs_o), 512'(mflat()));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/axil_reg_responder.md
# axil_reg_responder

AXI4-Lite slave that terminates the PS-to-PL register bus and exposes a bank of 32-bit control/status registers to fabric logic. It answers register writes and reads from the Zynq initiator or the simulation BFM, including byte strobes and error responses. Register 0 holds a read-only identifier used by bring-up scripts to check the link.

## Interface
- ADDR_WIDTH, 12, AXI address width; word index = addr[ADDR_WIDTH-1:2]
- NUM_REGS, 16, register count (2..1024); index 0 is read-only ID
- ID_VALUE, 32'h5052_4F50, value returned by register 0
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- s_awaddr / s_awvalid / s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp / s_bvalid / s_bready  out/out/in  2/1/1  write response channel
- s_araddr / s_arvalid / s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_rdata / s_rresp / s_rvalid / s_rready  out/out/out/in  32/2/1/1  read data channel
- regs_o  out  32*NUM_REGS  flat register contents, reg i at [32*i+31:32*i]
- wr_pulse_o  out  NUM_REGS  one-cycle strobe per register on committed write

## Operation
- Write FSM: W_COLLECT, W_RESP.
  - W_COLLECT: s_awready high until AW is captured; s_wready high until W is captured. AW and W are accepted in either order or in the same cycle; each is held once captured.
  - On the edge where the second of AW/W is captured: decode, commit, set s_bvalid, go to W_RESP.
  - W_RESP: s_awready=s_wready=0; hold s_bvalid/s_bresp until s_bready, then return to W_COLLECT with both captures cleared.
- Commit rules:
  - Index >= NUM_REGS: no update, DECERR (2'b11).
  - Index 0: no update, SLVERR (2'b10).
  - Otherwise byte k is updated iff s_wstrb[k], OKAY (2'b00); wr_pulse_o[index] high for exactly one cycle, even if wstrb=0.
- Read FSM: R_IDLE, R_RESP.
  - R_IDLE: s_arready=1. On handshake, sample the register (or ID_VALUE) into s_rdata, set s_rvalid, go to R_RESP.
  - Out of range: s_rdata=0, DECERR.
  - R_RESP: s_arready=0; hold s_rdata/s_rresp/s_rvalid stable until s_rready, then return to R_IDLE.
- Read and write FSMs are independent.
  - If a read samples and a write commits to the same register on the same edge, the read returns the pre-write value.
- addr[1:0] is ignored; no unaligned error.

## Timing
- Reset (rst=0 at an edge) clears everything:
  - all VALIDs, READYs and wr_pulse_o low; s_bresp, s_rresp, s_rdata = 0;
  - regs_o = 0 except slot 0 = ID_VALUE;
  - both FSMs to idle, pending captures discarded.
  - Applies mid-transaction, with no response issued for the aborted transfer.
- READY signals rise the first cycle after rst is released.
- Write latency: s_bvalid and updated regs_o are visible the cycle after the final AW/W handshake; wr_pulse_o is in the same cycle as the first s_bvalid.
- Read latency: s_rvalid the cycle after the AR handshake.
- Throughput with READY held high: one write per 2 cycles, one read per 2 cycles; reads and writes may overlap.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package axil_pkg:
  - response constants AXI_RESP_OKAY/SLVERR/DECERR;
  - write and read state enums;
  - pure function for word-index decode and range check.
- Single module; no sub-module is needed. The byte-strobe merge stays inline as a function in the package.

## Test plan
- Reset then read addr 0x000 -> RVALID one cycle after AR, rdata 0x50524F50, OKAY; read 0x004 -> 0x00000000.
- AW 0x008 and W 0xDEADBEEF/strb 0xF in the same cycle -> BVALID next cycle with OKAY; regs_o[2]=0xDEADBEEF; wr_pulse_o[2] one cycle; readback matches.
- W 0x000000AA strb 0x1 three cycles before AW 0x008 (reg 2 = 0xDEADBEEF) -> reg 2 = 0xDEADBEAA; BVALID is held 4 cycles while bready=0, then drops after the handshake.
- Write 0x000 -> SLVERR and ID unchanged; write and read 0x040 (NUM_REGS=16) -> DECERR, rdata 0.
- Read of reg 3 on the same edge as a write commit to reg 3 (old 0x1, new 0x2) -> rdata 0x1; the next read returns 0x2.
- rst asserted while BVALID pending -> next cycle bvalid=0, all regs cleared; a new write afterwards completes normally.
